// File: rtl/rbz_pkg.sv
// rbz_pkg: shared channel level codes and span FSM encodings.
package rbz_pkg;
    localparam logic [1:0] LVL_0 = 2'b00, LVL_1 = 2'b01, LVL_2 = 2'b10, LVL_3 = 2'b11;
    localparam logic [1:0] ST_WAIT = 2'd0, ST_IN = 2'd1, ST_DONE = 2'd2;
endpackage

// File: rtl/span_if.sv
// span_if: tracer-to-renderer span handshake.
interface span_if #(parameter int SIZE_W = 11);
    logic in_valid, in_ready, in_side;
    logic [SIZE_W-1:0] in_size;
    modport master(output in_valid, in_size, in_side, input in_ready);
    modport slave(input in_valid, in_size, in_side, output in_ready);
endinterface

// File: rtl/dither_cell.sv
// dither_cell: maps a 2-bit channel level to a 1-bit ordered-dithered pixel.
module dither_cell
    import rbz_pkg::*;
(
    input  logic [1:0] c,
    input  logic       xo,
    input  logic       yo,
    input  logic       field,
    output logic       o
);
    assign o = c == LVL_3 ? 1'b1 :
               c == LVL_2 ? xo ^ yo ^ field :
               c == LVL_1 ? (xo ^ field) & (yo ^ field) : 1'b0;
endmodule

// File: rtl/span_render.sv
// span_render: double-buffered per-line wall span renderer with optional dithering.
module span_render
    import rbz_pkg::*;
#(
    parameter int H_VIEW = 640,
    parameter int SIZE_W = 11,
    parameter logic [5:0] COLOR0 = 6'b10_00_00,
    parameter logic [5:0] COLOR1 = 6'b11_00_00,
    parameter int DITHER = 0,
    localparam int OUT_W = DITHER != 0 ? 1 : 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic             frame_start,
    input  logic [9:0]       hpos,
    input  logic             visible,
    span_if.slave            s,
    output logic [OUT_W-1:0] r,
    output logic [OUT_W-1:0] g,
    output logic [OUT_W-1:0] b,
    output logic             hit,
    output logic             underrun
);
    localparam int W = SIZE_W + 1;
    localparam logic [W-1:0] HALF = W'(H_VIEW / 2);
    localparam logic [W-1:0] LAST = W'(H_VIEW - 1);

    logic pend_valid, pend_side, act_side, xfer, hit_d, side_c;
    logic [SIZE_W-1:0] pend_size;
    logic [W-1:0] left, right, nl, nr, hp, sum;
    logic [1:0] state, nstate;
    logic [5:0] col;
    logic [OUT_W-1:0] rc, gc, bc;

    // The slot frees on line_start, so a same-cycle transfer refills it.
    assign s.in_ready = !pend_valid || line_start;
    assign xfer = s.in_valid && s.in_ready;
    assign hp = W'(hpos);
    assign sum = HALF + W'(pend_size);
    assign nl = W'(pend_size) >= HALF ? '0 : HALF - W'(pend_size);
    assign nr = sum > LAST ? LAST : sum;
    assign side_c = line_start ? pend_side : act_side;
    assign col = side_c ? COLOR1 : COLOR0;

    always_comb begin
        nstate = state;
        if (line_start)
            nstate = !pend_valid ? ST_DONE : nl == '0 ? ST_IN : ST_WAIT;
        else if (state == ST_WAIT && hp == left)
            nstate = hp == right ? ST_DONE : ST_IN;
        else if (state == ST_IN && hp == right)
            nstate = ST_DONE;
    end

    // Pixel 0 is judged against the span being promoted this cycle.
    assign hit_d = visible && (line_start ? pend_valid && nl == '0 :
                   state == ST_IN || (state == ST_WAIT && hp == left));

    if (DITHER != 0) begin : g_dith
        logic yo, field, yo_c, field_c;
        assign yo_c = frame_start ? 1'b0 : yo ^ line_start;
        assign field_c = field ^ frame_start;
        always_ff @(posedge clk)
            if (!reset_n) {yo, field} <= '0;
            else {yo, field} <= {yo_c, field_c};
        dither_cell u_r (.c(col[1:0]), .xo(hpos[0]), .yo(yo_c), .field(field_c), .o(rc));
        dither_cell u_g (.c(col[3:2]), .xo(hpos[0]), .yo(yo_c), .field(field_c), .o(gc));
        dither_cell u_b (.c(col[5:4]), .xo(hpos[0]), .yo(yo_c), .field(field_c), .o(bc));
    end else begin : g_flat
        assign {bc, gc, rc} = col;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_size <= '0;
            pend_side <= 1'b0;
            act_side <= 1'b0;
            left <= '0;
            right <= '0;
            state <= ST_DONE;
            hit <= 1'b0;
            r <= '0;
            g <= '0;
            b <= '0;
            underrun <= 1'b0;
        end else begin
            pend_valid <= xfer || (pend_valid && !line_start);
            if (xfer) begin
                pend_size <= s.in_size;
                pend_side <= s.in_side;
            end
            if (line_start) begin
                left <= nl;
                right <= nr;
                act_side <= pend_side;
            end
            state <= nstate;
            hit <= hit_d;
            r <= hit_d ? rc : '0;
            g <= hit_d ? gc : '0;
            b <= hit_d ? bc : '0;
            underrun <= (line_start && !pend_valid) || (underrun && !frame_start);
        end
    end
endmodule

// File: tb/tb_span_render.sv
// tb_span_render: directed checks of span_render, flat and dithered builds.
module tb_span_render;
    logic clk = 0, reset_n = 0, line_start = 0, frame_start = 0, visible = 0;
    logic [9:0] hpos = 0;
    logic [1:0] r, g, b;
    logic hit, underrun, dr, dg, db, dhit, dund;
    logic [5:0] exp_col;
    logic px0, px1;
    int total = 0, bad_n = 0;
    int n_hit, first, last, bad, rdy1, lit_a, lit_b, p00_a;

    span_if #(.SIZE_W(11)) a();
    span_if #(.SIZE_W(11)) d();
    assign d.in_valid = a.in_valid;
    assign d.in_size = a.in_size;
    assign d.in_side = a.in_side;

    span_render dut (.clk(clk), .reset_n(reset_n), .line_start(line_start), .frame_start(frame_start),
        .hpos(hpos), .visible(visible), .s(a), .r(r), .g(g), .b(b), .hit(hit), .underrun(underrun));
    span_render #(.DITHER(1)) dut_d (.clk(clk), .reset_n(reset_n), .line_start(line_start),
        .frame_start(frame_start), .hpos(hpos), .visible(visible), .s(d), .r(dr), .g(dg), .b(db),
        .hit(dhit), .underrun(dund));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sz, input bit sd);
        a.in_valid = 1;
        a.in_size = 11'(sz);
        a.in_side = sd;
        hpos = 10'd700;
        visible = 0;
        line_start = 0;
        frame_start = 0;
        step();
        a.in_valid = 0;
    endtask

    task automatic run_line(input bit fs, input bit lx = 0, input int lsz = 0, input bit lsd = 0);
        n_hit = 0; first = -1; last = -1; bad = 0; rdy1 = 0;
        for (int h = 0; h < 644; h++) begin
            hpos = 10'(h);
            visible = h < 640;
            line_start = h == 0;
            frame_start = fs && h == 0;
            a.in_valid = lx && h == 0;
            a.in_size = 11'(lsz);
            a.in_side = lsd;
            #1;
            if (h != 0 && a.in_ready) rdy1++;
            step();
            if (hit) begin
                n_hit++;
                if (first < 0) first = h;
                last = h;
                if ({b, g, r} !== exp_col) bad++;
            end else if ({b, g, r} !== 6'd0) bad++;
            if (h == 0) px0 = db;
            if (h == 1) px1 = db;
        end
        line_start = 0;
        frame_start = 0;
        a.in_valid = 0;
        visible = 0;
    endtask

    initial begin
        a.in_valid = 0; a.in_size = 0; a.in_side = 0;
        step(); step();
        chk("rst_hit", hit, 0);
        chk("rst_rgb", {b, g, r}, 0);
        chk("rst_ready", a.in_ready, 1);
        chk("rst_underrun", underrun, 0);
        reset_n = 1;

        send(100, 0);
        chk("s1_ready_after_xfer", a.in_ready, 0);
        exp_col = 6'b10_00_00;
        run_line(1);
        chk("s1_count", n_hit, 201);
        chk("s1_first", first, 220);
        chk("s1_last", last, 420);
        chk("s1_colour", bad, 0);
        chk("s1_underrun", underrun, 0);
        chk("s1_ready_after_line", a.in_ready, 1);

        send(400, 1);
        exp_col = 6'b11_00_00;
        run_line(0);
        chk("s2_count", n_hit, 640);
        chk("s2_first", first, 0);
        chk("s2_last", last, 639);
        chk("s2_colour", bad, 0);

        send(0, 0);
        exp_col = 6'b10_00_00;
        run_line(0);
        chk("s3_count", n_hit, 1);
        chk("s3_first", first, 320);
        chk("s3_last", last, 320);

        run_line(0);
        chk("s4_count", n_hit, 0);
        chk("s4_underrun", underrun, 1);
        run_line(1);
        chk("s4_fs_same_cycle", underrun, 1);
        send(50, 0);
        run_line(1);
        chk("s4_cleared", underrun, 0);
        chk("s4_count", n_hit, 101);
        chk("s4_first", first, 270);

        send(10, 0);
        send(300, 1);
        run_line(0, 1, 200, 1);
        chk("s5_old_count", n_hit, 21);
        chk("s5_old_first", first, 310);
        chk("s5_old_last", last, 330);
        chk("s5_old_colour", bad, 0);
        chk("s5_ready_low", rdy1, 0);
        exp_col = 6'b11_00_00;
        run_line(0);
        chk("s5_new_count", n_hit, 401);
        chk("s5_new_first", first, 120);
        chk("s5_new_last", last, 520);
        chk("s5_new_colour", bad, 0);
        chk("s5_ready_after", a.in_ready, 1);

        exp_col = 6'b10_00_00;
        run_line(0);
        chk("s6_underrun_set", underrun, 1);
        send(100, 0);
        for (int h = 0; h <= 300; h++) begin
            hpos = 10'(h);
            visible = 1;
            line_start = h == 0;
            a.in_valid = h == 100;
            a.in_size = 11'd5;
            a.in_side = 0;
            reset_n = h != 300;
            step();
            if (h == 299) begin
                chk("s6_pre_hit", hit, 1);
                chk("s6_pre_ready", a.in_ready, 0);
                chk("s6_pre_underrun", underrun, 1);
            end
        end
        line_start = 0;
        a.in_valid = 0;
        #1;
        chk("s6_hit", hit, 0);
        chk("s6_ready", a.in_ready, 1);
        chk("s6_underrun", underrun, 0);
        chk("s6_rgb", {b, g, r}, 0);
        reset_n = 1;
        run_line(1);
        chk("s6_after_count", n_hit, 0);
        chk("s6_after_underrun", underrun, 1);

        send(400, 0);
        run_line(1);
        p00_a = int'(px0);
        lit_a = int'(px0) + int'(px1);
        send(400, 0);
        run_line(0);
        lit_a += int'(px0) + int'(px1);
        send(400, 0);
        run_line(1);
        chk("dith_p00_a", p00_a, 0);
        chk("dith_p00_b", px0, 1);
        lit_b = int'(px0) + int'(px1);
        send(400, 0);
        run_line(0);
        lit_b += int'(px0) + int'(px1);
        chk("dith_lit_a", lit_a, 2);
        chk("dith_lit_b", lit_b, 2);
        chk("dith_rg", {dr, dg}, 0);

        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end
endmodule

// File: doc/span_render.md
SPAN_RENDER -- requirements
Module: span_render

Interface
REQ-001 The block SHALL have parameter H_VIEW, default 640, meaning the visible line width in pixels.
REQ-002 The block SHALL have parameter SIZE_W, default 11, meaning the span half-size width in bits.
REQ-003 The block SHALL have parameter COLOR0, default 6'b10_00_00 ({b,g,r}), meaning the wall colour for side 0.
REQ-004 The block SHALL have parameter COLOR1, default 6'b11_00_00, meaning the wall colour for side 1.
REQ-005 The block SHALL have parameter DITHER, default 0, meaning 0 selects 2-bit channel outputs and 1 selects 1-bit ordered-dithered outputs; OUT_W = DITHER ? 1 : 2.
REQ-006 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse, coincident with hpos==0.
- frame_start  in  1  one-cycle pulse, coincident with the first line_start of a frame.
- hpos  in  10  current pixel column.
- visible  in  1  pixel is in the active area.
- in_valid  in  1  tracer offers the span for the next line.
- in_ready  out  1  pending slot is empty.
- in_size  in  SIZE_W  span half-size.
- in_side  in  1  wall side.
- r, g, b  out  OUT_W each  pixel colour.
- hit  out  1  pixel lies inside the active span.
- underrun  out  1  sticky flag: a line started with no pending span.

Function
REQ-007 A transfer SHALL occur on any cycle where in_valid && in_ready; it loads the pending register {size, side} and clears in_ready on the next cycle.
REQ-008 On line_start, the pending span SHALL be promoted to the active span, and in_ready SHALL be 1 on the following cycle.
REQ-009 A transfer and a line_start in the same cycle SHALL promote the old pending span and capture the new one; in_ready SHALL stay 0.
REQ-010 line_start with no pending span SHALL mark the active span invalid for that line (hit=0 on every pixel of the line) and SHALL set underrun.
REQ-011 On promotion the block SHALL precompute left and right edges:
- left = (size >= H_VIEW/2) ? 0 : H_VIEW/2 - size.
- right = min(H_VIEW/2 + size, H_VIEW-1).
- All arithmetic SHALL be done at SIZE_W+1 bits with no wrap; size=0 gives the single pixel 320 (for H_VIEW=640).
REQ-012 A 3-state span FSM SHALL run with states WAIT, IN and DONE:
- line_start moves to IN if left==0, else to WAIT.
- WAIT moves to IN when hpos==left.
- IN moves to DONE on the cycle after hpos==right.
- DONE holds until the next line_start.
- An invalid span goes straight to DONE.
REQ-013 hit SHALL equal span_valid && left<=hpos<=right && visible, registered, with exactly 1 cycle latency from hpos.
REQ-014 r/g/b SHALL be zero whenever registered hit is 0.
REQ-015 When hit is 1 and DITHER=0, r/g/b SHALL carry COLOR0 or COLOR1 according to the active side.
REQ-016 When DITHER=1, each 2-bit level c SHALL map to a 1-bit output:
- c=11 gives 1.
- c=10 gives (xo^yo^field).
- c=01 gives (xo^field)&(yo^field).
- c=00 gives 0.
- xo=hpos[0].
- yo is an internal line-parity bit that toggles on each line_start and clears on frame_start.
- field is an internal bit that toggles on each frame_start.
REQ-017 underrun SHALL clear only on reset or frame_start; frame_start in the same cycle as an underrun event SHALL leave underrun set.

Reset
REQ-018 While reset_n=0 at a clk edge, the block SHALL clear all state:
- in_ready=1, no pending span, active span invalid, FSM=DONE.
- hit=0, r=g=b=0, underrun=0, field=0, yo=0.
REQ-019 Reset asserted mid-line SHALL discard the pending and active spans; the first line after reset SHALL underrun unless a transfer occurs before it.

Structure
REQ-020 The channel encoding constants (level codes 00..11) and the FSM state encodings SHALL live in a shared package, rbz_pkg.
REQ-021 The per-channel level-to-1-bit mapping SHALL be a single sub-module, dither_cell, instantiated three times when DITHER=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Transfer size=100, side=0, then line_start -> hit=1 for hpos 220..420 (delayed 1 cycle), r/g/b = COLOR0, zero elsewhere.
- size=400 -> hit=1 for hpos 0..639; size=0 -> hit only at hpos 320.
- No transfer before line_start -> hit=0 for the whole line, underrun=1; it clears on the next frame_start.
- Transfer on the same cycle as line_start -> old span renders this line, new span renders the next line, in_ready stays 0 throughout.
- DITHER=1, level 10, two consecutive frames -> the pixel (0,0) output toggles 0/1 and a 2x2 block shows 2 of 4 lit each frame.
- reset_n=0 at hpos 300 during an active span -> next cycle hit=0, in_ready=1, underrun=0.
